// File: rtl/pwm_duty_meter.sv
// PWM capture: measures period and high time of pwm_in and reports the duty cycle
// as a DUTY_RES-bit fraction, with stuck-line detection and overrun signalling.
module pwm_duty_meter #(
    parameter int DUTY_RES = 8,
    parameter int CNT_W    = 22,
    parameter int TIMEOUT  = 2500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [DUTY_RES-1:0] duty,
    output logic [CNT_W-1:0]    period,
    output logic [CNT_W-1:0]    high_time,
    output logic                valid,
    output logic                stuck,
    output logic                overrun
);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam int               BIT_W       = $clog2(DUTY_RES + 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DUTY_RES - 1);

    typedef enum logic [1:0] {ARM, MEAS, DIVIDE} state_t;
    state_t state_q, state_d;

    logic                s1, s2, s3;
    logic                rise;
    logic [CNT_W-1:0]    cnt, hcnt;
    logic [CNT_W-1:0]    div_p, div_h;
    logic                div_sat;
    logic [CNT_W:0]      rem, rem_sh, rem_nx;
    logic [DUTY_RES-1:0] quo, quo_nx;
    logic [BIT_W-1:0]    bit_idx;
    logic                q_bit;
    logic                timeout, start_div, drop_win, div_done;

    function automatic logic [DUTY_RES-1:0] sat_quo(input logic [DUTY_RES-1:0] q,
                                                    input logic ovf);
        return ovf ? {DUTY_RES{1'b1}} : q;
    endfunction

    function automatic logic [DUTY_RES-1:0] stuck_duty(input logic lvl);
        return lvl ? {DUTY_RES{1'b1}} : '0;
    endfunction

    assign rise      = s2 & ~s3;
    // A rise in the same cycle as the timeout takes precedence.
    assign timeout   = (cnt == TIMEOUT_CNT) && !rise;
    assign start_div = (state_q == MEAS) && rise;
    assign drop_win  = (state_q == DIVIDE) && rise;
    assign div_done  = (state_q == DIVIDE) && (bit_idx == LAST_BIT) && !timeout;

    assign rem_sh = rem << 1;
    assign q_bit  = (rem_sh >= {1'b0, div_p});
    assign rem_nx = q_bit ? (rem_sh - {1'b0, div_p}) : rem_sh;
    assign quo_nx = (quo << 1) | DUTY_RES'(q_bit);

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = ARM;
        end else begin
            case (state_q)
                ARM:     if (rise) state_d = MEAS;
                MEAS:    if (rise) state_d = DIVIDE;
                DIVIDE:  if (bit_idx == LAST_BIT) state_d = MEAS;
                default: state_d = ARM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            state_q   <= ARM;
            cnt       <= CNT_W'(1);
            hcnt      <= CNT_W'(1);
            bit_idx   <= '0;
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            s1      <= pwm_in;
            s2      <= s1;
            s3      <= s2;
            state_q <= state_d;
            valid   <= 1'b0;
            overrun <= drop_win;

            if (rise || timeout) begin
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
            end else begin
                cnt  <= cnt + 1'b1;
                hcnt <= hcnt + CNT_W'(s2);
            end

            if (start_div)
                bit_idx <= '0;
            else if (state_q == DIVIDE)
                bit_idx <= bit_idx + 1'b1;

            if (timeout) begin
                duty      <= stuck_duty(s2);
                period    <= '0;
                high_time <= '0;
                valid     <= 1'b1;
                stuck     <= 1'b1;
            end else if (div_done) begin
                duty      <= sat_quo(quo_nx, div_sat);
                period    <= div_p;
                high_time <= div_h;
                valid     <= 1'b1;
                stuck     <= 1'b0;
            end
        end
    end

    // Divider datapath: restoring division, one quotient bit per cycle.
    always_ff @(posedge clk) begin
        if (start_div) begin
            div_p   <= cnt;
            div_h   <= hcnt;
            div_sat <= (hcnt >= cnt);
            rem     <= {1'b0, hcnt};
            quo     <= '0;
        end else if (state_q == DIVIDE) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed testbench for pwm_duty_meter with TIMEOUT shortened to 5000 cycles.
module tb_pwm_duty_meter;
    localparam int DUTY_RES = 8;
    localparam int CNT_W    = 22;
    localparam int TIMEOUT  = 5000;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                pwm_in = 1'b0;
    logic [DUTY_RES-1:0] duty;
    logic [CNT_W-1:0]    period;
    logic [CNT_W-1:0]    high_time;
    logic                valid;
    logic                stuck;
    logic                overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nvalid = 0;
    int novr = 0;
    int vcyc = 0;
    int vcyc_prev = 0;

    pwm_duty_meter #(.DUTY_RES(DUTY_RES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .pwm_in(pwm_in), .duty(duty), .period(period),
        .high_time(high_time), .valid(valid), .stuck(stuck), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder for valid/overrun pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (valid) begin
            nvalid    <= nvalid + 1;
            vcyc_prev <= vcyc;
            vcyc      <= cyc;
        end
        if (overrun) novr <= novr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        pwm_in = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic run_pwm(input int p, input int h, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                pwm_in = (i < h);
                tick();
            end
        end
        pwm_in = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
        checks++; if (period !== 22'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
        checks++; if (high_time !== 22'd0) begin errors++; $display("FAIL reset_high_time: got %0d expected 0", high_time); end
        checks++; if ({valid, stuck, overrun} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid, stuck, overrun}); end
    endtask

    task automatic test_basic();
        int v0, c0;
        apply_reset();
        v0 = nvalid;
        run_pwm(1000, 250, 1);
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL basic_first_rise: got %0d valids expected 0", nvalid - v0); end
        c0 = cyc;
        run_pwm(1000, 250, 1);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL basic_count: got %0d valids expected 1", nvalid - v0); end
        checks++; if (vcyc - c0 !== 11) begin errors++; $display("FAIL basic_latency: got %0d expected 11", vcyc - c0); end
        checks++; if (period !== 22'd1000) begin errors++; $display("FAIL basic_period: got %0d expected 1000", period); end
        checks++; if (high_time !== 22'd250) begin errors++; $display("FAIL basic_high_time: got %0d expected 250", high_time); end
        checks++; if (duty !== 8'd64) begin errors++; $display("FAIL basic_duty: got %0d expected 64", duty); end
        run_pwm(1000, 250, 3);
        checks++; if (nvalid !== v0 + 4) begin errors++; $display("FAIL basic_repeat_count: got %0d valids expected 4", nvalid - v0); end
        checks++; if (vcyc - vcyc_prev !== 1000) begin errors++; $display("FAIL basic_repeat_interval: got %0d expected 1000", vcyc - vcyc_prev); end
        checks++; if (duty !== 8'd64) begin errors++; $display("FAIL basic_repeat_duty: got %0d expected 64", duty); end
    endtask

    // Each call completes the window driven by the previous call.
    task automatic test_duty_values();
        int hs[4]   = '{999, 1, 500, 500};
        int exp_d[3] = '{255, 0, 128};
        apply_reset();
        run_pwm(1000, hs[0], 1);
        for (int i = 1; i < 4; i++) begin
            run_pwm(1000, hs[i], 1);
            checks++; if (high_time !== 22'(hs[i-1])) begin errors++; $display("FAIL duty_values_high[%0d]: got %0d expected %0d", i, high_time, hs[i-1]); end
            checks++; if (duty !== 8'(exp_d[i-1])) begin errors++; $display("FAIL duty_values_duty[%0d]: got %0d expected %0d", i, duty, exp_d[i-1]); end
        end
    endtask

    task automatic test_duty_step();
        int hs[5]    = '{250, 250, 750, 750, 750};
        int exp_d[4] = '{64, 64, 192, 192};
        apply_reset();
        run_pwm(1000, hs[0], 1);
        for (int i = 1; i < 5; i++) begin
            run_pwm(1000, hs[i], 1);
            checks++; if (high_time !== 22'(hs[i-1])) begin errors++; $display("FAIL duty_step_high[%0d]: got %0d expected %0d", i, high_time, hs[i-1]); end
            checks++; if (duty !== 8'(exp_d[i-1])) begin errors++; $display("FAIL duty_step_duty[%0d]: got %0d expected %0d", i, duty, exp_d[i-1]); end
            checks++; if (period !== 22'd1000) begin errors++; $display("FAIL duty_step_period[%0d]: got %0d expected 1000", i, period); end
        end
    endtask

    task automatic test_timeout_high();
        int v0, c0;
        apply_reset();
        v0 = nvalid;
        c0 = cyc;
        pwm_in = 1'b1;
        repeat (10100) tick();
        pwm_in = 1'b0;
        checks++; if (nvalid !== v0 + 2) begin errors++; $display("FAIL timeout_high_count: got %0d valids expected 2", nvalid - v0); end
        checks++; if (vcyc_prev - c0 !== 5003) begin errors++; $display("FAIL timeout_high_first: got %0d expected 5003", vcyc_prev - c0); end
        checks++; if (vcyc - vcyc_prev !== 5000) begin errors++; $display("FAIL timeout_high_interval: got %0d expected 5000", vcyc - vcyc_prev); end
        checks++; if (duty !== 8'd255) begin errors++; $display("FAIL timeout_high_duty: got %0d expected 255", duty); end
        checks++; if ({period, high_time} !== 44'd0) begin errors++; $display("FAIL timeout_high_zero: got period %0d high %0d expected 0 0", period, high_time); end
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL timeout_high_stuck: got %b expected 1", stuck); end
    endtask

    task automatic test_timeout_low_resume();
        int v0;
        apply_reset();
        v0 = nvalid;
        repeat (5100) tick();
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL timeout_low_count: got %0d valids expected 1", nvalid - v0); end
        checks++; if (duty !== 8'd0) begin errors++; $display("FAIL timeout_low_duty: got %0d expected 0", duty); end
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL timeout_low_stuck: got %b expected 1", stuck); end
        run_pwm(1000, 250, 1);
        checks++; if (stuck !== 1'b1) begin errors++; $display("FAIL resume_stuck_held: got %b expected 1", stuck); end
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL resume_arm_only: got %0d valids expected 1", nvalid - v0); end
        run_pwm(1000, 250, 1);
        checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL resume_stuck_clear: got %b expected 0", stuck); end
        checks++; if (duty !== 8'd64) begin errors++; $display("FAIL resume_duty: got %0d expected 64", duty); end
        checks++; if (period !== 22'd1000) begin errors++; $display("FAIL resume_period: got %0d expected 1000", period); end
    endtask

    task automatic test_back_to_back();
        int v0, o0;
        apply_reset();
        v0 = nvalid; o0 = novr;
        run_pwm(8, 4, 10);
        repeat (20) tick();
        checks++; if (nvalid !== v0 + 5) begin errors++; $display("FAIL p8_valid_count: got %0d expected 5", nvalid - v0); end
        checks++; if (novr !== o0 + 4) begin errors++; $display("FAIL p8_overrun_count: got %0d expected 4", novr - o0); end
        checks++; if (duty !== 8'd128) begin errors++; $display("FAIL p8_duty: got %0d expected 128", duty); end
        checks++; if ({period, high_time} !== {22'd8, 22'd4}) begin errors++; $display("FAIL p8_meas: got period %0d high %0d expected 8 4", period, high_time); end
        apply_reset();
        v0 = nvalid; o0 = novr;
        run_pwm(9, 3, 10);
        repeat (20) tick();
        checks++; if (nvalid !== v0 + 9) begin errors++; $display("FAIL p9_valid_count: got %0d expected 9", nvalid - v0); end
        checks++; if (novr !== o0) begin errors++; $display("FAIL p9_overrun_count: got %0d expected 0", novr - o0); end
        checks++; if (duty !== 8'd85) begin errors++; $display("FAIL p9_duty: got %0d expected 85", duty); end
        checks++; if ({period, high_time} !== {22'd9, 22'd3}) begin errors++; $display("FAIL p9_meas: got period %0d high %0d expected 9 3", period, high_time); end
    endtask

    task automatic test_reset_mid_divide();
        int v0;
        apply_reset();
        run_pwm(1000, 250, 2);
        v0 = nvalid;
        checks++; if (duty !== 8'd64) begin errors++; $display("FAIL middiv_pre_duty: got %0d expected 64", duty); end
        pwm_in = 1'b1;
        repeat (6) tick();
        pwm_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({duty, period, high_time} !== '0) begin errors++; $display("FAIL middiv_outputs: got duty %0d period %0d high %0d expected 0 0 0", duty, period, high_time); end
        checks++; if ({valid, stuck, overrun} !== 3'b000) begin errors++; $display("FAIL middiv_flags: got %b expected 000", {valid, stuck, overrun}); end
        repeat (1000) tick();
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL middiv_no_valid: got %0d valids expected 0", nvalid - v0); end
        run_pwm(1000, 250, 1);
        checks++; if (nvalid !== v0) begin errors++; $display("FAIL middiv_first_rise: got %0d valids expected 0", nvalid - v0); end
        run_pwm(1000, 250, 1);
        checks++; if (nvalid !== v0 + 1) begin errors++; $display("FAIL middiv_second_rise: got %0d valids expected 1", nvalid - v0); end
        checks++; if (duty !== 8'd64) begin errors++; $display("FAIL middiv_duty: got %0d expected 64", duty); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_values();
        test_duty_step();
        test_timeout_high();
        test_timeout_low_resume();
        test_back_to_back();
        test_reset_mid_divide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Single-channel PWM capture block: measures the period and high time of an incoming PWM waveform and reports its duty cycle as a DUTY_RES-bit fraction. It is the receive side of the LED PWM generators. It is used on loopback and bench checks to confirm the duty ramps those generators produce.

## Interface
Parameters:
- DUTY_RES, 8: duty result width; duty = floor(high_time·2^DUTY_RES / period).
- CNT_W, 22: period/high-time counter width; must satisfy TIMEOUT < 2^CNT_W.
- TIMEOUT, 2500000: cycles without a rising edge before the line is declared stuck (20 ms at 125 MHz).

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  asynchronous PWM input.
- duty  out  DUTY_RES  last measured duty fraction.
- period  out  CNT_W  last measured period in clk cycles; 0 on stuck report.
- high_time  out  CNT_W  last measured high cycles; 0 on stuck report.
- valid  out  1  one-cycle pulse when duty/period/high_time update.
- stuck  out  1  level; set by timeout report, cleared by the next real measurement.
- overrun  out  1  one-cycle pulse when a measured window is discarded.

## Operation
- Input path: pwm_in passes through a 2-FF synchronizer (s1, s2), then a history FF (s3). rise = s2 & ~s3. All three FFs reset to 0.
- Window definition: the cycle where rise is asserted is cycle 0 of a window.
  - P = cycles from one rise to the next.
  - H = cycles in that window with s2 = 1, including the rise cycle.
  - Synchronous input gives H ≤ P−1.
- cnt and hcnt run continuously. On rise, both are captured and reloaded: cnt ← 1, hcnt ← 1.
- States:
  - ARM (reset state): waits for the first rise. That rise only starts a window and produces no result. → MEAS.
  - MEAS: on rise with the divider idle, latch P/H into the divider, start DIVIDE, and keep counting the next window.
  - DIVIDE: restoring divide, one quotient bit per cycle, DUTY_RES cycles.
    - rem initialises to H.
    - Each step: rem ← rem<<1; if rem ≥ P then rem −= P and the quotient bit is 1.
    - rem width is CNT_W+1.
    - Completion: register duty/period/high_time, pulse valid, clear stuck, return to MEAS.
    - Quotient is saturated to 2^DUTY_RES−1 (unreachable when H < P).
- Overrun: a rise during DIVIDE (i.e. P ≤ DUTY_RES) discards the new window and pulses overrun. The in-flight division still completes. Counters reload as normal.
- Timeout: in any state, if cnt reaches TIMEOUT with no rise:
  - duty ← all ones if s2 = 1, else 0.
  - period ← 0, high_time ← 0.
  - valid pulses and stuck ← 1.
  - State → ARM, an in-flight division is aborted, and cnt ← 1.
  - The report repeats every TIMEOUT cycles while the line stays constant.
- Reset: valid/overrun 0, stuck 0, duty/period/high_time 0, state ARM, counters 1. Reset during DIVIDE aborts it with no valid. After release, two rises are needed before the first result.

## Timing
- pwm_in transition to rise: rise asserts 2 cycles after pwm_in is first sampled high.
- Rise in cycle R: valid is high in cycle R+DUTY_RES+1, with outputs stable from that cycle until the next update.
- Minimum accepted period: DUTY_RES+1 cycles. Results arrive once per period.
- Simultaneous rise and timeout in the same cycle: rise wins and no stuck report is made.
- valid and overrun never assert in the same cycle for the same window. Both may be high in one cycle only if the completion and a discarded window coincide.

## Test plan
- Reset, then a PWM with P=1000, H=250 → no result on the first rise. valid 9 cycles after the second rise with period=1000, high_time=250, duty=64. Repeats every 1000 cycles.
- H=999, P=1000 → duty=255. H=1, P=1000 → duty=0. H=500, P=1000 → duty=128.
- TIMEOUT=5000, pwm_in held high after reset → valid at ~5000 cycles with duty=255, period=0, stuck=1. Repeats every 5000 cycles. Held low → duty=0. Resuming P=1000, H=250 → stuck clears at the first real valid (duty=64).
- P=8, H=4 → overrun pulse on alternating rises, with the previous result still delivered. P=9, H=3 → valid every period, duty=85, no overrun.
- Assert rst for 1 cycle at R+4 during DIVIDE → no valid. All outputs 0 the next cycle. First new result only after two further rises.
- Duty step 25%→75% at P=1000 → the transitional window reports its exact H. The following window reports duty=192.
